// File: rtl/uart_cmd_parser.sv
// ASCII debug command parser: assembles "<op>[hex]<CR>" frames from UART bytes
// and hands the decoded opcode/argument to the debug core over valid/ready.
module uart_cmd_parser #(
  parameter int unsigned ARG_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       d_rx,
  input  logic             vld_rx,
  output logic             rdy_rx,
  output logic [2:0]       cmd_op,
  output logic [ARG_W-1:0] cmd_arg,
  output logic             cmd_vld,
  input  logic             cmd_rdy,
  output logic             err,
  output logic             ovr,
  output logic             busy
);

  localparam int unsigned MAX_DIG = ARG_W / 4;
  localparam int unsigned CNT_W   = $clog2(MAX_DIG + 1);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {IDLE, ARG, ERR, ISSUE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [ARG_W-1:0]   arg_q, arg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         cmd_op_q, cmd_op_d;
  logic [ARG_W-1:0]   cmd_arg_q, cmd_arg_d;
  logic               rdy_q, cmd_vld_q, err_q, err_d, ovr_q, busy_q;
  logic               accept, tmo;
  logic [4:0]         hx;
  logic [2:0]         op_in;

  // Case-insensitive opcode letter decode; 0 means not an opcode.
  function automatic logic [2:0] op_of(input logic [7:0] b);
    logic [2:0] r;
    unique case (b | 8'h20)
      8'h72:   r = 3'd1;
      8'h77:   r = 3'd2;
      8'h64:   r = 3'd3;
      8'h67:   r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Bit 4 flags a hex digit, bits 3:0 hold its value.
  function automatic logic [4:0] hex_of(input logic [7:0] b);
    logic [4:0] r;
    r = '0;
    if (b >= 8'h30 && b <= 8'h39)      r = {1'b1, 4'(b - 8'h30)};
    else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
    else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
    return r;
  endfunction

  assign accept = vld_rx && rdy_q;
  assign tmo    = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign hx     = hex_of(d_rx);
  assign op_in  = op_of(d_rx);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    cnt_d     = cnt_q;
    tmr_d     = '0;
    cmd_op_d  = cmd_op_q;
    cmd_arg_d = cmd_arg_q;
    err_d     = 1'b0;

    // Inter-byte timer only runs while a frame is open; an accepted byte wins over expiry.
    if ((state_q == ARG || state_q == ERR) && !accept) tmr_d = tmr_q + TMR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (accept && d_rx != CH_CR && d_rx != CH_LF && d_rx != CH_SP) begin
          if (op_in != 3'd0) begin
            op_d    = op_in;
            arg_d   = '0;
            cnt_d   = '0;
            state_d = ARG;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      ARG: begin
        if (accept) begin
          if (hx[4]) begin
            if (cnt_q == CNT_W'(MAX_DIG)) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              arg_d = (arg_q << 4) | ARG_W'(hx[3:0]);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (d_rx == CH_CR) begin
            cmd_op_d  = op_q;
            cmd_arg_d = arg_q;
            state_d   = ISSUE;
          end else if (d_rx != CH_SP) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        if (accept ? (d_rx == CH_CR) : tmo) state_d = IDLE;
      end
      ISSUE: begin
        if (cmd_vld_q && cmd_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      op_q      <= '0;
      arg_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      cmd_op_q  <= '0;
      cmd_arg_q <= '0;
      rdy_q     <= 1'b1;
      cmd_vld_q <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      cmd_op_q  <= cmd_op_d;
      cmd_arg_q <= cmd_arg_d;
      rdy_q     <= (state_d != ISSUE);
      cmd_vld_q <= (state_d == ISSUE);
      err_q     <= err_d;
      ovr_q     <= vld_rx && !rdy_q;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign rdy_rx  = rdy_q;
  assign cmd_op  = cmd_op_q;
  assign cmd_arg = cmd_arg_q;
  assign cmd_vld = cmd_vld_q;
  assign err     = err_q;
  assign ovr     = ovr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed protocol/timing steps plus random frames
// checked against a frame-level parsing model.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 100;
  localparam logic [7:0]  CR  = 8'h0d;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  d_rx = 8'h00;
  logic        vld_rx = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic        rdy_rx, cmd_vld, err, ovr, busy;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;

  int n_cmp = 0;
  int n_fail = 0;
  int err_n = 0;
  int cmd_n = 0;
  logic [2:0]  log_op[0:1023];
  logic [31:0] log_arg[0:1023];
  bit rand_rdy = 1'b0;

  int          m_err;
  logic [34:0] m_cmd[$];

  uart_cmd_parser #(.ARG_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .d_rx(d_rx), .vld_rx(vld_rx), .rdy_rx(rdy_rx),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .err(err), .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observe err pulses and completed handshakes between edges.
  always begin
    @(negedge clk);
    #2;
    if (rstn) begin
      if (err === 1'b1) err_n++;
      if (cmd_vld === 1'b1 && cmd_rdy && cmd_n < 1024) begin
        log_op[cmd_n]  = cmd_op;
        log_arg[cmd_n] = cmd_arg;
        cmd_n++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (rand_rdy) cmd_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t line(input string s);
    bq_t q;
    q = s2q(s);
    q.push_back(CR);
    return q;
  endfunction

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [2:0] opcode_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    if (u == "R") return 3'd1;
    if (u == "W") return 3'd2;
    if (u == "D") return 3'd3;
    if (u == "G") return 3'd4;
    return 3'd0;
  endfunction

  // One CR-terminated segment: optional blanks, opcode letter, up to 8 hex digits with spaces.
  task automatic eval_seg(input bq_t seg);
    int i, digits, h;
    logic [2:0]  op;
    logic [31:0] val;
    i = 0;
    while (i < seg.size() && (seg[i] == 8'h0a || seg[i] == 8'h20)) i++;
    if (i == seg.size()) return;
    op = opcode_of(seg[i]);
    if (op == 3'd0) begin m_err++; return; end
    digits = 0;
    val = 32'd0;
    for (int j = i + 1; j < seg.size(); j++) begin
      if (seg[j] == 8'h20) continue;
      h = hexval(seg[j]);
      if (h < 0) begin m_err++; return; end
      digits++;
      if (digits > 8) begin m_err++; return; end
      val = (val << 4) | 32'(h);
    end
    m_cmd.push_back({op, val});
  endtask

  task automatic model(input bq_t q);
    bq_t seg;
    m_err = 0;
    m_cmd.delete();
    foreach (q[i]) begin
      if (q[i] == CR) begin
        eval_seg(seg);
        seg.delete();
      end else begin
        seg.push_back(q[i]);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (rdy_rx !== 1'b1 && w < 500) begin tick(); w++; end
    if (w >= 500) check("rdy_wait", 64'(rdy_rx), 64'(1));
    d_rx   = b;
    vld_rx = 1'b1;
    tick();
    vld_rx = 1'b0;
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic verify(input bq_t q, input int be, input int bc);
    int w;
    w = 0;
    while (cmd_vld === 1'b1 && w < 500) begin tick(); w++; end
    tick();
    tick();
    model(q);
    check("err_count", 64'(err_n - be), 64'(m_err));
    check("cmd_count", 64'(cmd_n - bc), 64'(m_cmd.size()));
    for (int i = 0; i < m_cmd.size() && bc + i < cmd_n; i++) begin
      check("cmd_op", 64'(log_op[bc + i]), 64'(m_cmd[i][34:32]));
      check("cmd_arg", 64'(log_arg[bc + i]), 64'(m_cmd[i][31:0]));
    end
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  function automatic bq_t rand_frame();
    bq_t q;
    string ops, hexs;
    int nd;
    ops  = "RWDGrwdg";
    hexs = "0123456789abcdefABCDEF";
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      case ($urandom_range(0, 2))
        0:       q.push_back(8'h0a);
        1:       q.push_back(8'h20);
        default: q.push_back(CR);
      endcase
    end
    if ($urandom_range(0, 7) == 0) q.push_back(8'($urandom_range(8'h21, 8'h7e)));
    else q.push_back(ops[$urandom_range(0, 7)]);
    nd = int'($urandom_range(0, 9));
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 5) == 0) q.push_back(8'h20);
      if ($urandom_range(0, 19) == 0) q.push_back(8'($urandom_range(8'h21, 8'h7e)));
      q.push_back(hexs[$urandom_range(0, 21)]);
    end
    q.push_back(CR);
    return q;
  endfunction

  initial begin
    bq_t q;
    int be, bc, k, held;

    rstn = 1'b0;
    repeat (3) tick();
    check("rst_rdy_rx", 64'(rdy_rx), 64'(1));
    check("rst_cmd_vld", 64'(cmd_vld), 64'(0));
    check("rst_cmd_op", 64'(cmd_op), 64'(0));
    check("rst_cmd_arg", 64'(cmd_arg), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_ovr", 64'(ovr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rstn = 1'b1;
    tick();

    // R1234 with cmd_rdy held high: single-cycle cmd_vld right after CR.
    cmd_rdy = 1'b1;
    be = err_n; bc = cmd_n;
    q = line("R1234");
    send_q(s2q("R1234"));
    check("busy_in_frame", 64'(busy), 64'(1));
    send_byte(CR);
    check("cr_vld_next", 64'(cmd_vld), 64'(1));
    check("cr_rdy_low", 64'(rdy_rx), 64'(0));
    tick();
    check("pulse_vld_drop", 64'(cmd_vld), 64'(0));
    check("pulse_rdy_back", 64'(rdy_rx), 64'(1));
    verify(q, be, bc);

    // Stalled command: held while cmd_rdy=0, overrun byte dropped.
    cmd_rdy = 1'b0;
    be = err_n; bc = cmd_n;
    q = line("w DEADbeef");
    send_q(q);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_vld === 1'b1 && rdy_rx === 1'b0) held++;
      if (i == 6) check("ovr_pulse", 64'(ovr), 64'(1));
      if (i == 7) check("ovr_width", 64'(ovr), 64'(0));
      d_rx   = 8'h41;
      vld_rx = (i == 5);
      tick();
    end
    vld_rx = 1'b0;
    check("stall_held_cycles", 64'(held), 64'(20));
    check("stall_op", 64'(cmd_op), 64'(2));
    check("stall_arg", 64'(cmd_arg), 64'(32'hdeadbeef));
    check("stall_no_take", 64'(cmd_n - bc), 64'(0));
    cmd_rdy = 1'b1;
    tick();
    check("take_vld_drop", 64'(cmd_vld), 64'(0));
    check("take_rdy_back", 64'(rdy_rx), 64'(1));
    verify(q, be, bc);

    // Too many digits, then a bare opcode.
    be = err_n; bc = cmd_n;
    q = {line("R123456789"), line("G")};
    send_q(q);
    verify(q, be, bc);

    // Bad opcode, then a good frame.
    be = err_n; bc = cmd_n;
    q = {line("X12"), line("D5")};
    send_q(q);
    verify(q, be, bc);

    // Inter-byte timeout inside ARG.
    be = err_n;
    send_q(s2q("R12"));
    k = 0;
    while (err !== 1'b1 && k < 300) begin tick(); k++; end
    check("tmo_latency", 64'(k), 64'(TMO));
    check("tmo_busy", 64'(busy), 64'(0));
    tick();
    check("tmo_err_width", 64'(err), 64'(0));
    check("tmo_err_count", 64'(err_n - be), 64'(1));
    be = err_n; bc = cmd_n;
    q = line("R7");
    send_q(q);
    verify(q, be, bc);

    // A byte landing on the expiry cycle beats the timeout.
    be = err_n; bc = cmd_n;
    send_q(s2q("R1"));
    repeat (TMO - 1) tick();
    send_q(line("2"));
    verify(line("R12"), be, bc);

    // Reset mid-frame discards the partial command.
    send_q(s2q("W5"));
    rstn = 1'b0;
    tick();
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_op", 64'(cmd_op), 64'(0));
    check("mid_rst_arg", 64'(cmd_arg), 64'(0));
    check("mid_rst_rdy", 64'(rdy_rx), 64'(1));
    rstn = 1'b1;
    tick();
    be = err_n; bc = cmd_n;
    q = line("");
    send_q(q);
    verify(q, be, bc);
    check("post_rst_op", 64'(cmd_op), 64'(0));
    check("post_rst_arg", 64'(cmd_arg), 64'(0));
    check("post_rst_vld", 64'(cmd_vld), 64'(0));
    check("post_rst_ovr", 64'(ovr), 64'(0));

    // Random frames with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      q = rand_frame();
      be = err_n; bc = cmd_n;
      send_q(q);
      verify(q, be, bc);
    end
    rand_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser/sequencer for the serial debug unit. Consumes received bytes from the UART receiver through its `vld_rx`/`rdy_rx` handshake and assembles ASCII debug commands of the form `<op>[hex digits]<CR>`. Presents each decoded command (opcode plus binary argument) to the debug core over a valid/ready handshake. Handles malformed input, inter-byte timeout and overrun.

## Interface
Parameters:
- `ARG_W`, 32, argument width in bits; multiple of 4; max hex digits = ARG_W/4
- `TIMEOUT_CYC`, 5000000, idle cycles allowed between bytes inside a frame (50 ms at 100 MHz)

Ports:
- `clk` in 1 system clock, 100 MHz
- `rstn` in 1 reset, asynchronous, active-low
- `d_rx` in 8 received byte from UART receiver
- `vld_rx` in 1 byte valid pulse from UART receiver
- `rdy_rx` out 1 parser can accept a byte
- `cmd_op` out 3 opcode: 1=R, 2=W, 3=D, 4=G; 0 = none
- `cmd_arg` out ARG_W parsed hex argument
- `cmd_vld` out 1 command valid, held until taken
- `cmd_rdy` in 1 debug core accepts command
- `err` out 1 one-cycle pulse: syntax error or timeout
- `ovr` out 1 one-cycle pulse: byte arrived while `rdy_rx`=0 (byte dropped)
- `busy` out 1 frame in progress (state ≠ IDLE)

## Operation
- Byte accepted on a cycle with `vld_rx`=1 and `rdy_rx`=1; no other bytes are examined.
- States: IDLE, ARG, ERR, ISSUE.
- IDLE: 0x0D, 0x0A, 0x20 ignored. 'R'/'r', 'W'/'w', 'D'/'d', 'G'/'g' → latch opcode, clear arg and digit count, clear timer → ARG. Any other byte → `err` pulse → ERR.
- ARG: hex digit (0-9, A-F, a-f) → `arg <= {arg[ARG_W-5:0], nibble}`, digit count +1; 0x20 ignored; 0x0D → ISSUE; any other byte, or a digit when count already = ARG_W/4 → `err` pulse → ERR.
- ARG timeout: timer increments each cycle with no accepted byte and resets on every accepted byte; reaching TIMEOUT_CYC → `err` pulse → IDLE, frame discarded.
- CR with zero digits is legal: command issued with `cmd_arg`=0.
- ERR: all bytes discarded until 0x0D → IDLE. Timeout also applies in ERR (→ IDLE, no extra `err`).
- ISSUE: `cmd_vld`=1, `cmd_op`/`cmd_arg` stable; `rdy_rx`=0. On `cmd_vld`&&`cmd_rdy` → IDLE.
- `ovr` pulses whenever `vld_rx`=1 while `rdy_rx`=0; that byte is lost and state unchanged.
- `cmd_op`/`cmd_arg` hold their last values outside ISSUE; only `cmd_vld` qualifies them.

## Timing
- Reset (rstn=0, async): state IDLE, `rdy_rx`=1, `cmd_vld`=0, `cmd_op`=0, `cmd_arg`=0, `err`=0, `ovr`=0, `busy`=0, timer 0, digit count 0.
- All outputs registered; `rdy_rx` = (next state ≠ ISSUE), registered.
- CR accepted at cycle N → `cmd_vld`=1 and `rdy_rx`=0 at N+1.
- Handshake at cycle M → `cmd_vld`=0, `rdy_rx`=1 at M+1; earliest next byte accepted at M+1.
- `cmd_rdy` may be held high in advance: command then consumed at N+1, one-cycle `cmd_vld`.
- `err` asserts the cycle after the offending byte or the timer-expiry cycle; width exactly 1.
- Timeout: byte accepted at cycle T with no later byte → `err` at T+TIMEOUT_CYC+1.
- `vld_rx` and timer expiry in the same cycle: the byte wins, timer clears.
- Reset mid-frame or mid-ISSUE: partial command discarded, no `cmd_vld`.

## Test plan
- Send "R1234\r", `cmd_rdy`=1 → one `cmd_vld` pulse, `cmd_op`=1, `cmd_arg`=0x00001234, no `err`.
- Send "w DEADbeef\r", `cmd_rdy`=0 for 20 cycles → `cmd_vld` held 20 cycles, `cmd_op`=2, `cmd_arg`=0xDEADBEEF, `rdy_rx`=0 throughout; byte pulsed meanwhile → `ovr`=1 for 1 cycle, command unchanged.
- Send "R123456789\r" (9 digits, ARG_W=32) → `err` after 9th digit, no command; following "G\r" → `cmd_op`=4, `cmd_arg`=0.
- Send "X12\r" then "D5\r" → `err` once after 'X', then command `cmd_op`=3, `cmd_arg`=5.
- TIMEOUT_CYC=100: send "R12", wait 101 cycles → `err` at 101st cycle after '2', `busy`=0; then "R7\r" → `cmd_arg`=7.
- Assert `rstn`=0 after "W5", release, send "\r" → no `cmd_vld`, no `err`, all outputs at reset values.
